hazard_unit: RTL and testbench

- Tracks destination registers of in-flight instructions in EX, MEM and WB using its own shadow pipeline.
- Produces the stall signal and the per-operand forwarding selects that drive the ID-stage bypass muxes for rs and rt.
- Also tracks multi-cycle mult/div occupancy and stalls HI/LO consumers until the result is ready.
- Sits beside the ID stage; all inputs come from the decoder and the pipeline control.

---
 rtl/hazard_unit_pkg.sv | 41 ++++
 rtl/hazard_match.sv | 30 +++
 rtl/hazard_unit.sv | 152 +++++++++++++++
 tb/tb_hazard_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_unit_pkg
// Shared definitions for the ID-stage hazard unit: register/data widths,
// forwarding-select encodings, the shadow-pipeline stage record and a helper
// that picks the bypass source for one operand.
// -----------------------------------------------------------------------------
package hazard_unit_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // One shadow-pipeline stage: who is written, whether, and by a load.
    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic             we;
        logic             is_load;
    } shadow_t;

    localparam shadow_t SHADOW_BUBBLE = '{dst: 5'd0, we: 1'b0, is_load: 1'b0};

    // Youngest non-load producer wins; a MEM load is never a bypass source
    // because its data only exists in WB (the stall logic covers that case).
    function automatic logic [1:0] fwd_pick(input logic mem_hit,
                                            input logic mem_is_load,
                                            input logic wb_hit);
        logic [1:0] sel;
        if (mem_hit && !mem_is_load) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Combinational compare of one source operand against one shadow stage.
// Ports:
//   src_reg  - source register number read by the ID instruction
//   src_used - the ID instruction actually reads src_reg
//   dst      - destination register held in the shadow stage
//   we       - the shadow stage writes the register file
//   hit      - operand depends on this stage ($0 never hits)
// -----------------------------------------------------------------------------
module hazard_match
    import hazard_unit_pkg::*;
(
    input  logic [REG_W-1:0] src_reg,
    input  logic             src_used,
    input  logic [REG_W-1:0] dst,
    input  logic             we,
    output logic             hit
);

    // Dependency detect; $0 is hard-wired so it is excluded explicitly.
    always_comb begin
        if (src_used && (src_reg != {REG_W{1'b0}}) && we && (dst == src_reg)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// ID-stage hazard detection. Keeps a private shadow of {dst, we, is_load} for
// EX, MEM and WB, derives the RAW stall and the rs/rt bypass selects, and
// tracks mult/div occupancy of HI/LO.
//
// Build option: HAZARD_FORWARD_EN
//   defined     - MEM/WB bypassing; stall only on EX hits and MEM-load hits.
//   not defined - selects tied to FWD_REG; any EX/MEM/WB hit stalls until the
//                 producer has retired and the register file holds the value.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   id_valid, id_flush       - ID holds a real / killed instruction
//   id_rs, id_rt             - source registers, id_rs_used/id_rt_used qualify
//   id_dst, id_we            - destination and write enable
//   id_is_load               - instruction is a load
//   id_is_muldiv             - instruction starts a mult/div
//   id_reads_hilo            - mfhi/mflo
//   stall                    - freeze PC and IF/ID, bubble into EX
//   fwd_rs_sel, fwd_rt_sel   - 0 regfile, 1 MEM data, 2 WB data
//   hilo_busy                - mult/div result not yet in HI/LO
// -----------------------------------------------------------------------------
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4,
    parameter int CNT_W          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_flush,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             id_is_muldiv,
    input  logic             id_reads_hilo,
    output logic             stall,
    output logic [1:0]       fwd_rs_sel,
    output logic [1:0]       fwd_rt_sel,
    output logic             hilo_busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    shadow_t          ex_r, mem_r, wb_r;
    shadow_t          stage_s [3];
    logic [CNT_W-1:0] cnt_r;

    logic [2:0]       rs_hit_s, rt_hit_s;   // index 0 = EX, 1 = MEM, 2 = WB
    logic             id_live_s;
    logic             raw_stall_s;
    logic             hilo_busy_s;
    logic             stall_s;
    logic             issue_s;
    logic [1:0]       fwd_rs_s, fwd_rt_s;
    logic             unused_shadow_s;

    assign stage_s[0] = ex_r;
    assign stage_s[1] = mem_r;
    assign stage_s[2] = wb_r;

    for (genvar g = 0; g < 3; g++) begin : g_match
        hazard_match u_rs_match (
            .src_reg (id_rs),
            .src_used(id_rs_used),
            .dst     (stage_s[g].dst),
            .we      (stage_s[g].we),
            .hit     (rs_hit_s[g])
        );
        hazard_match u_rt_match (
            .src_reg (id_rt),
            .src_used(id_rt_used),
            .dst     (stage_s[g].dst),
            .we      (stage_s[g].we),
            .hit     (rt_hit_s[g])
        );
    end

    // WB is_load is kept for a uniform stage record but never consulted.
    assign unused_shadow_s = wb_r.is_load;

    assign id_live_s   = id_valid & ~id_flush;
    assign hilo_busy_s = (cnt_r != CNT_ZERO);

    // RAW hazard and bypass selection for both operands.
    always_comb begin
        raw_stall_s = 1'b0;
        fwd_rs_s    = FWD_REG;
        fwd_rt_s    = FWD_REG;
`ifdef HAZARD_FORWARD_EN
        // EX results are not yet available; a load in MEM only delivers in WB.
        raw_stall_s = rs_hit_s[0] | rt_hit_s[0]
                    | (mem_r.is_load & (rs_hit_s[1] | rt_hit_s[1]));
        fwd_rs_s    = fwd_pick(rs_hit_s[1], mem_r.is_load, rs_hit_s[2]);
        fwd_rt_s    = fwd_pick(rt_hit_s[1], mem_r.is_load, rt_hit_s[2]);
`else
        // No bypass paths: wait until the producer has left WB.
        raw_stall_s = (|rs_hit_s) | (|rt_hit_s) | (mem_r.is_load & 1'b0);
`endif
    end

    // A killed or empty ID slot never stalls; flush therefore beats stall.
    always_comb begin
        if (id_live_s) begin
            stall_s = raw_stall_s
                    | (hilo_busy_s & (id_reads_hilo | id_is_muldiv));
        end else begin
            stall_s = 1'b0;
        end
    end

    assign issue_s = id_live_s & id_is_muldiv & ~stall_s;

    // Shadow pipeline advance and mult/div occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_r  <= SHADOW_BUBBLE;
            mem_r <= SHADOW_BUBBLE;
            wb_r  <= SHADOW_BUBBLE;
            cnt_r <= CNT_ZERO;
        end else begin
            wb_r  <= mem_r;
            mem_r <= ex_r;
            if (id_live_s && !stall_s) begin
                ex_r <= '{dst: id_dst, we: id_we, is_load: id_is_load};
            end else begin
                ex_r <= SHADOW_BUBBLE;
            end
            if (issue_s) begin
                cnt_r <= CNT_LOAD;
            end else if (hilo_busy_s) begin
                cnt_r <= cnt_r - CNT_ONE;
            end else begin
                cnt_r <= CNT_ZERO;
            end
        end
    end

    assign stall      = stall_s;
    assign fwd_rs_sel = fwd_rs_s;
    assign fwd_rt_sel = fwd_rt_s;
    assign hilo_busy  = hilo_busy_s;

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Directed scenarios with literal expectations, followed by randomized
// instruction streams checked every cycle against a behavioural model that
// tracks the three in-flight instructions and the remaining mult/div cycles.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    localparam int LAT = 4;

`ifdef HAZARD_FORWARD_EN
    localparam int ALU_STALLS  = 1;
    localparam int ALU_RS_SEL  = 1;
    localparam int NEXT_RT_SEL = 2;
    localparam int LOAD_STALLS = 2;
    localparam int LOAD_RT_SEL = 2;
    localparam int MEMWB_STALL = 0;
    localparam int MEMWB_SEL   = 1;
`else
    localparam int ALU_STALLS  = 3;
    localparam int ALU_RS_SEL  = 0;
    localparam int NEXT_RT_SEL = 0;
    localparam int LOAD_STALLS = 3;
    localparam int LOAD_RT_SEL = 0;
    localparam int MEMWB_STALL = 1;
    localparam int MEMWB_SEL   = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_flush;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       id_rs_used, id_rt_used, id_we, id_is_load, id_is_muldiv, id_reads_hilo;
    logic       stall, hilo_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_unit #(.MULDIV_LATENCY(LAT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_flush(id_flush),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_dst(id_dst), .id_we(id_we), .id_is_load(id_is_load),
        .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .hilo_busy(hilo_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0] dst;
        bit         we;
        bit         ld;
    } ent_t;

    ent_t pipe [3];          // [0] = one instruction ahead (EX), [2] = oldest (WB)
    int   busy_left = 0;     // cycles until HI/LO is ready
    bit   model_ok  = 1'b0;
    bit   exp_stall;
    int   exp_rs, exp_rt;

    // Stage index of the youngest in-flight writer of r, or -1.
    function automatic int youngest(input logic [4:0] r, input logic used);
        if (!used || r == 5'd0) return -1;
        for (int k = 0; k < 3; k++)
            if (pipe[k].we && pipe[k].dst == r) return k;
        return -1;
    endfunction

    function automatic int sel_of(input int k);
        if (k == 1 && !pipe[1].ld) return 1;
        if (k == 2) return 2;
        return 0;
    endfunction

    function automatic void predict();
        int ks, kt;
        bit haz;
        ks  = youngest(id_rs, id_rs_used);
        kt  = youngest(id_rt, id_rt_used);
`ifdef HAZARD_FORWARD_EN
        haz = (ks == 0) || (kt == 0) || (pipe[1].ld && (ks == 1 || kt == 1));
        exp_rs = sel_of(ks);
        exp_rt = sel_of(kt);
`else
        haz = (ks >= 0) || (kt >= 0);
        exp_rs = 0;
        exp_rt = 0;
`endif
        if (busy_left > 0 && (id_reads_hilo || id_is_muldiv)) haz = 1'b1;
        exp_stall = id_valid && !id_flush && haz;
    endfunction

    // Compare at negedge, advance the model at posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                predict();
                chk("stall", stall, exp_stall);
                chk("hilo_busy", hilo_busy, busy_left > 0);
`ifdef HAZARD_FORWARD_EN
                if (id_valid && !id_flush && !exp_stall) begin
                    chk("fwd_rs_sel", fwd_rs_sel, exp_rs);
                    chk("fwd_rt_sel", fwd_rt_sel, exp_rt);
                end
`else
                chk("fwd_rs_sel", fwd_rs_sel, 0);
                chk("fwd_rt_sel", fwd_rt_sel, 0);
`endif
            end
            @(posedge clk);
            if (rst) begin
                for (int k = 0; k < 3; k++) pipe[k] = '{dst: 5'd0, we: 1'b0, ld: 1'b0};
                busy_left = 0;
                model_ok  = 1'b1;
            end else if (model_ok) begin
                predict();
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                if (id_valid && !id_flush && !exp_stall)
                    pipe[0] = '{dst: id_dst, we: id_we, ld: id_is_load};
                else
                    pipe[0] = '{dst: 5'd0, we: 1'b0, ld: 1'b0};
                if (id_valid && !id_flush && id_is_muldiv && !exp_stall) busy_left = LAT;
                else if (busy_left > 0) busy_left--;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_flush = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        id_dst = 5'd0; id_we = 1'b0; id_is_load = 1'b0;
        id_is_muldiv = 1'b0; id_reads_hilo = 1'b0;
    endtask

    task automatic issue(input int rs, input int rt, input bit rsu, input bit rtu,
                         input int dst, input bit we, input bit ld, input bit md, input bit rh);
        id_valid = 1'b1; id_flush = 1'b0;
        id_rs = 5'(rs); id_rt = 5'(rt); id_rs_used = rsu; id_rt_used = rtu;
        id_dst = 5'(dst); id_we = we; id_is_load = ld;
        id_is_muldiv = md; id_reads_hilo = rh;
    endtask

    // Hold the current ID instruction and count stall cycles (bounded).
    // Returns positioned mid-cycle with stall low (or at the bound).
    task automatic count_stalls(output int n, input bit check_busy);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            #3;
            if (stall !== 1'b1) break;
            if (check_busy) chk("busy_during_stall", hilo_busy, 1'b1);
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        idle();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("idle_stall", stall, 1'b0);
            chk("idle_rs", fwd_rs_sel, 2'd0);
            chk("idle_rt", fwd_rt_sel, 2'd0);
            chk("idle_busy", hilo_busy, 1'b0);
            tick();
        end

        // addu $3 <- $1,$2 ; consumer reads rs=$3 ; next reads rt=$3
        issue(1, 2, 1, 1, 3, 1, 0, 0, 0);
        #3 chk("addu_issue", stall, 1'b0);
        tick();
        issue(3, 0, 1, 0, 6, 1, 0, 0, 0);
        count_stalls(n, 1'b0);
        chk("alu_stall_cycles", n, ALU_STALLS);
        chk("alu_fwd_rs", fwd_rs_sel, ALU_RS_SEL);
        tick();
        issue(0, 3, 0, 1, 7, 0, 0, 0, 0);
        #3;
        chk("next_stall", stall, 1'b0);
        chk("next_fwd_rt", fwd_rt_sel, NEXT_RT_SEL);
        tick();

        // lw $5 ; consumer reads rt=$5
        issue(1, 0, 1, 0, 5, 1, 1, 0, 0);
        tick();
        issue(0, 5, 0, 1, 8, 1, 0, 0, 0);
        count_stalls(n, 1'b0);
        chk("load_stall_cycles", n, LOAD_STALLS);
        chk("load_fwd_rt", fwd_rt_sel, LOAD_RT_SEL);
        tick();

        // write $0 then read $0
        issue(0, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        issue(0, 0, 1, 0, 9, 0, 0, 0, 0);
        #3;
        chk("zero_stall", stall, 1'b0);
        chk("zero_fwd_rs", fwd_rs_sel, 2'd0);
        tick();

        // $4 in WB and MEM together, then read rs=$4
        issue(0, 0, 0, 0, 4, 1, 0, 0, 0);
        tick();
        issue(0, 0, 0, 0, 4, 1, 0, 0, 0);
        tick();
        idle();
        tick();
        issue(4, 0, 1, 0, 10, 0, 0, 0, 0);
        #3;
        chk("memwb_stall", stall, MEMWB_STALL);
        chk("memwb_fwd_rs", fwd_rs_sel, MEMWB_SEL);
        tick();
        idle();
        repeat (4) tick();

        // mult then mfhi
        issue(1, 2, 1, 1, 0, 0, 0, 1, 0);
        #3 chk("mult_issue", stall, 1'b0);
        tick();
        issue(0, 0, 0, 0, 11, 1, 0, 0, 1);
        count_stalls(n, 1'b1);
        chk("hilo_stall_cycles", n, LAT);
        chk("hilo_done_busy", hilo_busy, 1'b0);
        tick();
        idle();
        tick();

        // reset during a mult/div stall
        issue(1, 2, 1, 1, 0, 0, 0, 1, 0);
        tick();
        issue(0, 0, 0, 0, 11, 1, 0, 0, 1);
        #3 chk("rst_pre_stall1", stall, 1'b1);
        tick();
        #3 chk("rst_pre_stall2", stall, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #3;
        chk("rst_post_stall", stall, 1'b0);
        chk("rst_post_busy", hilo_busy, 1'b0);
        tick();

        // randomized instruction stream
        for (int c = 0; c < 3000; c++) begin
            id_valid      = ($urandom_range(0, 99) < 85);
            id_flush      = ($urandom_range(0, 99) < 10);
            id_rs         = 5'($urandom_range(0, 7));
            id_rt         = 5'($urandom_range(0, 7));
            id_rs_used    = ($urandom_range(0, 99) < 80);
            id_rt_used    = ($urandom_range(0, 99) < 60);
            id_dst        = 5'($urandom_range(0, 7));
            id_we         = ($urandom_range(0, 99) < 70);
            id_is_load    = ($urandom_range(0, 99) < 30);
            id_is_muldiv  = ($urandom_range(0, 99) < 6);
            id_reads_hilo = ($urandom_range(0, 99) < 12);
            rst           = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
